// File: rtl/rgmii_tx_framer.sv
// Gigabit RGMII transmit framer: wraps AXI-Stream MAC bytes with preamble/SFD, pad, FCS and IFG,
// and presents per-cycle rising/falling nibble and TX_CTL pairs for the output DDR stage.
module rgmii_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter bit          ENABLE_FCS   = 1'b1,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       phy_clk,
  input  logic       phy_rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] txd_q1,
  output logic [3:0] txd_q2,
  output logic       tx_ctl_q1,
  output logic       tx_ctl_q2,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StFcs,
    StDrain,
    StIfg
  } state_e;

  localparam logic [15:0] PreLast    = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IfgLast    = 16'(IFG_BYTES - 1);
  localparam logic [16:0] MinFrame   = 17'(MIN_FRAME);
  localparam state_e      PostFrame  = (IFG_BYTES == 0) ? StIdle : StIfg;
  localparam state_e      PostBody   = ENABLE_FCS ? StFcs : PostFrame;
  localparam bit          DoneOnBody = !ENABLE_FCS;

  state_e      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] slot_q, slot_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        tx_en_q, tx_en_d;
  logic        ctl2_q, ctl2_d;
  logic        done_q, done_d;
  logic        urun_q, urun_d;

  logic [15:0] cnt_sat;
  logic [16:0] cnt_inc;
  logic [31:0] crc_inv;

  // Reflected CRC-32 (0xEDB88320), data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  always_comb begin
    cnt_sat = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
    cnt_inc = {1'b0, byte_cnt_q} + 17'd1;
    crc_inv = ~crc_q;
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    slot_d        = slot_q;
    crc_d         = crc_q;
    out_byte_d    = 8'h00;
    tx_en_d       = 1'b0;
    ctl2_d        = 1'b0;
    done_d        = 1'b0;
    urun_d        = 1'b0;
    s_axis_tready = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The first preamble byte goes out on the same edge that samples tvalid.
        if (s_axis_tvalid) begin
          out_byte_d = 8'h55;
          tx_en_d    = 1'b1;
          ctl2_d     = 1'b1;
          slot_d     = 16'd1;
          state_d    = (PREAMBLE_LEN > 1) ? StPreamble : StSfd;
        end
      end
      StPreamble: begin
        out_byte_d = 8'h55;
        tx_en_d    = 1'b1;
        ctl2_d     = 1'b1;
        slot_d     = slot_q + 16'd1;
        if (slot_q == PreLast) begin
          state_d = StSfd;
        end
      end
      StSfd: begin
        out_byte_d = 8'hD5;
        tx_en_d    = 1'b1;
        ctl2_d     = 1'b1;
        crc_d      = 32'hFFFF_FFFF;
        byte_cnt_d = 16'd0;
        slot_d     = 16'd0;
        state_d    = StData;
      end
      StData: begin
        s_axis_tready = 1'b1;
        slot_d        = 16'd0;
        if (s_axis_tvalid) begin
          out_byte_d = s_axis_tdata;
          tx_en_d    = 1'b1;
          ctl2_d     = ~s_axis_tuser;
          crc_d      = crc32_byte(crc_q, s_axis_tdata);
          byte_cnt_d = cnt_sat;
          if (s_axis_tlast) begin
            if (cnt_inc < MinFrame) begin
              state_d = StPad;
            end else begin
              state_d = PostBody;
              done_d  = DoneOnBody;
            end
          end
        end else begin
          // Starved mid-frame: poison the current slot with TX_ER and abandon the frame.
          tx_en_d = 1'b1;
          ctl2_d  = 1'b0;
          urun_d  = 1'b1;
          state_d = StDrain;
        end
      end
      StPad: begin
        out_byte_d = 8'h00;
        tx_en_d    = 1'b1;
        ctl2_d     = 1'b1;
        crc_d      = crc32_byte(crc_q, 8'h00);
        byte_cnt_d = cnt_sat;
        slot_d     = 16'd0;
        if (cnt_inc >= MinFrame) begin
          state_d = PostBody;
          done_d  = DoneOnBody;
        end
      end
      StFcs: begin
        out_byte_d = crc_inv[{slot_q[1:0], 3'b000} +: 8];
        tx_en_d    = 1'b1;
        ctl2_d     = 1'b1;
        slot_d     = slot_q + 16'd1;
        if (slot_q[1:0] == 2'd3) begin
          done_d  = 1'b1;
          slot_d  = 16'd0;
          state_d = PostFrame;
        end
      end
      StDrain: begin
        s_axis_tready = 1'b1;
        slot_d        = 16'd0;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = PostFrame;
        end
      end
      StIfg: begin
        slot_d = slot_q + 16'd1;
        if (slot_q == IfgLast) begin
          slot_d  = 16'd0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (phy_rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= 16'd0;
      slot_q     <= 16'd0;
      crc_q      <= 32'hFFFF_FFFF;
      out_byte_q <= 8'h00;
      tx_en_q    <= 1'b0;
      ctl2_q     <= 1'b0;
      done_q     <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      slot_q     <= slot_d;
      crc_q      <= crc_d;
      out_byte_q <= out_byte_d;
      tx_en_q    <= tx_en_d;
      ctl2_q     <= ctl2_d;
      done_q     <= done_d;
      urun_q     <= urun_d;
    end
  end

  assign txd_q1     = out_byte_q[3:0];
  assign txd_q2     = out_byte_q[7:4];
  assign tx_ctl_q1  = tx_en_q;
  assign tx_ctl_q2  = ctl2_q;
  assign frame_done = done_q;
  assign underrun   = urun_q;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed bench for rgmii_tx_framer: logs every output cycle and checks framed bursts against
// hand-built expected byte streams with a bench-side CRC-32.
module tb_rgmii_tx_framer;

  localparam int PreLen = 7;
  localparam int MinFr  = 60;

  logic       phy_clk = 1'b0;
  logic       phy_rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic [3:0] txd_q1;
  logic [3:0] txd_q2;
  logic       tx_ctl_q1;
  logic       tx_ctl_q2;
  logic       frame_done;
  logic       underrun;

  always #4 phy_clk = ~phy_clk;

  rgmii_tx_framer #(
    .PREAMBLE_LEN(7),
    .MIN_FRAME   (60),
    .ENABLE_FCS  (1'b1),
    .IFG_BYTES   (12)
  ) dut (
    .phy_clk      (phy_clk),
    .phy_rst      (phy_rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .txd_q1       (txd_q1),
    .txd_q2       (txd_q2),
    .tx_ctl_q1    (tx_ctl_q1),
    .tx_ctl_q2    (tx_ctl_q2),
    .frame_done   (frame_done),
    .underrun     (underrun)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] lg_byte [0:4095];
  logic       lg_en   [0:4095];
  logic       lg_c2   [0:4095];
  logic       lg_done [0:4095];
  logic       lg_ur   [0:4095];
  logic       lg_rdy  [0:4095];
  int         lg_n = 0;

  always @(negedge phy_clk) begin
    if (lg_n < 4096) begin
      lg_byte[lg_n] <= {txd_q2, txd_q1};
      lg_en[lg_n]   <= tx_ctl_q1;
      lg_c2[lg_n]   <= tx_ctl_q2;
      lg_done[lg_n] <= frame_done;
      lg_ur[lg_n]   <= underrun;
      lg_rdy[lg_n]  <= s_axis_tready;
      lg_n          <= lg_n + 1;
    end
  end

  logic [7:0] pay[$];
  logic [7:0] exp_q[$];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic build_exp(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    int          body;
    c = 32'hFFFF_FFFF;
    exp_q.delete();
    for (int i = 0; i < PreLen; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    body = (n < MinFr) ? MinFr : n;
    for (int i = 0; i < body; i++) begin
      b = (i < n) ? pay[i] : 8'h00;
      exp_q.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  // First contiguous TX_EN run at or after index 'from'.
  task automatic find_burst(input int from, output int s, output int len);
    s = -1;
    len = 0;
    for (int i = from; i < lg_n; i++) begin
      if (s < 0) begin
        if (lg_en[i] === 1'b1) begin
          s = i;
          len = 1;
        end
      end else if (len == i - s && lg_en[i] === 1'b1) begin
        len++;
      end
    end
  endtask

  task automatic send(input int n, input int user_idx, input int drop_after, input bit keep,
                      input int stop_at);
    int i;
    int cyc;
    bit acc;
    i = 0;
    cyc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pay[0];
    s_axis_tlast  = (n == 1);
    s_axis_tuser  = (user_idx == 0);
    while (i < n && i != stop_at && cyc < 3000) begin
      @(negedge phy_clk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge phy_clk);
      #1;
      cyc++;
      if (acc) begin
        i++;
        if (i == drop_after) s_axis_tvalid = 1'b0;
      end else if (!s_axis_tvalid) begin
        s_axis_tvalid = 1'b1;
      end
      if (i < n) begin
        s_axis_tdata = pay[i];
        s_axis_tlast = (i == n - 1);
        s_axis_tuser = (i == user_idx);
      end
    end
    if (cyc >= 3000) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: accepted %0d of %0d bytes", i, n);
    end
    if (!keep) begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
  endtask

  task automatic test_reset();
    phy_rst = 1'b1;
    repeat (3) @(posedge phy_clk);
    @(negedge phy_clk);
    tests++;
    if ({txd_q2, txd_q1, tx_ctl_q1, tx_ctl_q2, frame_done, underrun} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 000",
               {txd_q2, txd_q1, tx_ctl_q1, tx_ctl_q2, frame_done, underrun});
    end
    tests++;
    if (s_axis_tready !== 1'b0) begin
      fails++;
      $display("FAIL reset_tready: got %b want 0", s_axis_tready);
    end
    phy_rst = 1'b0;
    repeat (4) @(posedge phy_clk);
    @(negedge phy_clk);
    tests++;
    if (tx_ctl_q1 !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_tvalid: tx_en got %b want 0", tx_ctl_q1);
    end
  endtask

  task automatic test_full_frame();
    int st, s, len, bad, nd, nr;
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i));
    build_exp(64);
    st = lg_n;
    send(64, -1, -1, 1'b0, -1);
    repeat (120) @(posedge phy_clk);
    #1;
    find_burst(st, s, len);
    tests++;
    if (len !== 76) begin
      fails++;
      $display("FAIL full_len: got %0d want 76", len);
    end
    if (s < 0) s = st;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && lg_byte[s+i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL full_bytes: slot %0d got %h want %h", bad, lg_byte[s+bad], exp_q[bad]);
    end
    nd = 0;
    nr = 0;
    for (int i = st; i < lg_n; i++) begin
      if (lg_done[i] === 1'b1) nd++;
      if (lg_rdy[i] === 1'b1) nr++;
    end
    tests++;
    if (lg_done[s+75] !== 1'b1 || nd != 1) begin
      fails++;
      $display("FAIL full_done: last-slot %b count %0d want 1 and 1", lg_done[s+75], nd);
    end
    tests++;
    if (nr != 64 || lg_rdy[s+7] !== 1'b1 || lg_rdy[s+6] !== 1'b0) begin
      fails++;
      $display("FAIL full_tready: count %0d at_sfd %b before %b want 64 1 0",
               nr, lg_rdy[s+7], lg_rdy[s+6]);
    end
  endtask

  task automatic test_short_frame();
    int st, s, len, bad, nd;
    pay = '{8'hAB};
    build_exp(1);
    st = lg_n;
    send(1, -1, -1, 1'b0, -1);
    repeat (110) @(posedge phy_clk);
    #1;
    find_burst(st, s, len);
    tests++;
    if (len !== 72) begin
      fails++;
      $display("FAIL short_len: got %0d want 72", len);
    end
    if (s < 0) s = st;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && lg_byte[s+i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL short_bytes: slot %0d got %h want %h", bad, lg_byte[s+bad], exp_q[bad]);
    end
    nd = 0;
    for (int i = st; i < lg_n; i++) if (lg_done[i] === 1'b1) nd++;
    tests++;
    if (lg_done[s+71] !== 1'b1 || nd != 1) begin
      fails++;
      $display("FAIL short_done: last-slot %b count %0d want 1 and 1", lg_done[s+71], nd);
    end
  endtask

  task automatic test_back_to_back();
    int st, s1, l1, s2, l2, bad, nd, nr;
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i * 3 + 1));
    build_exp(64);
    st = lg_n;
    send(64, -1, -1, 1'b1, -1);
    send(64, -1, -1, 1'b0, -1);
    repeat (120) @(posedge phy_clk);
    #1;
    find_burst(st, s1, l1);
    if (s1 < 0) s1 = st;
    find_burst(s1 + l1, s2, l2);
    tests++;
    if (l1 !== 76 || l2 !== 76) begin
      fails++;
      $display("FAIL b2b_len: got %0d/%0d want 76/76", l1, l2);
    end
    tests++;
    if (s2 - (s1 + l1) !== 12) begin
      fails++;
      $display("FAIL b2b_gap: got %0d idle cycles want 12", s2 - (s1 + l1));
    end
    if (s2 < 0) s2 = st;
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && lg_byte[s2+i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL b2b_bytes2: slot %0d got %h want %h", bad, lg_byte[s2+bad], exp_q[bad]);
    end
    nd = 0;
    nr = 0;
    for (int i = st; i < lg_n; i++) begin
      if (lg_done[i] === 1'b1) nd++;
      if (lg_rdy[i] === 1'b1) nr++;
    end
    tests++;
    if (nd != 2 || nr != 128) begin
      fails++;
      $display("FAIL b2b_counts: done %0d tready %0d want 2 and 128", nd, nr);
    end
  endtask

  task automatic test_underrun();
    int st, s, len, s2, l2, bad, nd, nu, last_rdy;
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i + 100));
    build_exp(64);
    st = lg_n;
    send(64, -1, 10, 1'b1, -1);
    pay = '{8'h5A};
    send(1, -1, -1, 1'b0, -1);
    repeat (110) @(posedge phy_clk);
    #1;
    find_burst(st, s, len);
    tests++;
    if (len !== 19) begin
      fails++;
      $display("FAIL urun_len: got %0d want 19", len);
    end
    if (s < 0) s = st;
    bad = -1;
    for (int i = 0; i < 18; i++) if (bad < 0 && lg_byte[s+i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL urun_bytes: slot %0d got %h want %h", bad, lg_byte[s+bad], exp_q[bad]);
    end
    tests++;
    if (lg_byte[s+18] !== 8'h00 || lg_c2[s+18] !== 1'b0 || lg_ur[s+18] !== 1'b1) begin
      fails++;
      $display("FAIL urun_err_slot: byte %h ctl2 %b underrun %b want 00 0 1",
               lg_byte[s+18], lg_c2[s+18], lg_ur[s+18]);
    end
    find_burst(s + len, s2, l2);
    if (s2 < 0) s2 = lg_n;
    nd = 0;
    nu = 0;
    last_rdy = -1;
    for (int i = st; i < s2; i++) begin
      if (lg_done[i] === 1'b1) nd++;
      if (lg_ur[i] === 1'b1) nu++;
      if (lg_rdy[i] === 1'b1) last_rdy = i;
    end
    tests++;
    if (nd != 0 || nu != 1) begin
      fails++;
      $display("FAIL urun_pulses: done %0d underrun %0d want 0 and 1", nd, nu);
    end
    // Drain ends at the tlast edge; 12 IFG cycles plus the IDLE pickup cycle follow it.
    tests++;
    if (s2 - last_rdy !== 14) begin
      fails++;
      $display("FAIL urun_ifg: preamble %0d cycles after last drain tready want 14",
               s2 - last_rdy);
    end
    build_exp(1);
    bad = (l2 == 72) ? -1 : 0;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && lg_byte[s2+i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL urun_next_frame: len %0d slot %0d got %h want %h",
               l2, bad, lg_byte[s2+bad], exp_q[bad]);
    end
  endtask

  task automatic test_tuser();
    int st, s, len, bad, nd, nlow;
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i));
    build_exp(64);
    st = lg_n;
    send(64, 5, -1, 1'b0, -1);
    repeat (120) @(posedge phy_clk);
    #1;
    find_burst(st, s, len);
    if (s < 0) s = st;
    bad = (len == 76) ? -1 : 0;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && lg_byte[s+i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL tuser_frame: len %0d slot %0d got %h want %h",
               len, bad, lg_byte[s+bad], exp_q[bad]);
    end
    nlow = 0;
    for (int i = s; i < s + len; i++) if (lg_c2[i] === 1'b0) nlow++;
    tests++;
    if (lg_c2[s+13] !== 1'b0 || nlow != 1) begin
      fails++;
      $display("FAIL tuser_ctl2: slot13 %b low-count %0d want 0 and 1", lg_c2[s+13], nlow);
    end
    nd = 0;
    for (int i = st; i < lg_n; i++) if (lg_done[i] === 1'b1) nd++;
    tests++;
    if (lg_done[s+75] !== 1'b1 || nd != 1) begin
      fails++;
      $display("FAIL tuser_done: last-slot %b count %0d want 1 and 1", lg_done[s+75], nd);
    end
  endtask

  task automatic test_reset_midframe();
    int st0, st, s, len, bad;
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(255 - i));
    st0 = lg_n;
    send(64, -1, -1, 1'b1, 20);
    phy_rst = 1'b1;
    @(posedge phy_clk);
    #1;
    phy_rst = 1'b0;
    @(negedge phy_clk);
    st = lg_n;
    tests++;
    if ({txd_q2, txd_q1, tx_ctl_q1, tx_ctl_q2, frame_done, underrun, s_axis_tready} !== 13'h0)
    begin
      fails++;
      $display("FAIL midrst_outputs: got %h want 0000",
               {txd_q2, txd_q1, tx_ctl_q1, tx_ctl_q2, frame_done, underrun, s_axis_tready});
    end
    pay = '{8'h3C};
    build_exp(1);
    @(posedge phy_clk);
    #1;
    tests++;
    if (tx_ctl_q1 !== 1'b1 || txd_q1 !== 4'h5 || txd_q2 !== 4'h5) begin
      fails++;
      $display("FAIL midrst_first_pre: en %b q1 %h q2 %h want 1 5 5", tx_ctl_q1, txd_q1, txd_q2);
    end
    send(1, -1, -1, 1'b0, -1);
    repeat (110) @(posedge phy_clk);
    #1;
    find_burst(st0, s, len);
    tests++;
    if (len !== 28) begin
      fails++;
      $display("FAIL midrst_cut_len: got %0d want 28", len);
    end
    find_burst(st, s, len);
    if (s < 0) s = st;
    bad = (len == 72) ? -1 : 0;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && lg_byte[s+i] !== exp_q[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL midrst_new_frame: len %0d slot %0d got %h want %h",
               len, bad, lg_byte[s+bad], exp_q[bad]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    phy_rst       = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_back_to_back();
    test_underrun();
    test_tuser();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
